decoder2to4_hold: RTL and testbench



---
 rtl/decoder2to4_hold.sv | 81 ++++++++
 tb/tb_decoder2to4_hold.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder2to4_hold.sv
// rtl/decoder2to4_hold.sv - sequential 2-to-4 decoder with programmable hold, gap cycle and sticky history
module decoder2to4_hold #(
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] A,
  input  logic       valid,
  output logic       ready,
  output logic [3:0] Y,
  output logic       busy,
  output logic [3:0] hist,
  input  logic       clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] a_onehot;
  logic       accept;

  assign a_onehot = 4'b0001 << A;
  assign accept   = (state == IDLE) && valid;

  // ready/busy decode straight from the state register so an async reset
  // drops them in the same cycle as Y
  assign ready = (state == IDLE);
  assign busy  = (state == DRIVE) || (state == GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      Y     <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            Y     <= a_onehot;
            cnt   <= HOLD_M1;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == 8'd0) begin
            Y     <= 4'b0000;
            state <= GAP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          Y     <= 4'b0000;
          state <= IDLE;
        end
      endcase
    end
  end

  // a decode on the same edge as clr survives: clear first, then set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 4'b0000;
    end else if (accept) begin
      hist <= (clr ? 4'b0000 : hist) | a_onehot;
    end else if (clr) begin
      hist <= 4'b0000;
    end
  end

endmodule

// File: tb/tb_decoder2to4_hold.sv
// tb/tb_decoder2to4_hold.sv - self-checking bench for decoder2to4_hold
module tb_decoder2to4_hold;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] A = 2'd0;
  logic       valid = 1'b0;
  logic       clr = 1'b0;
  logic       ready;
  logic [3:0] Y;
  logic       busy;
  logic [3:0] hist;

  decoder2to4_hold #(.HOLD(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .valid (valid),
    .ready (ready),
    .Y     (Y),
    .busy  (busy),
    .hist  (hist),
    .clr   (clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference: timeline of edges counted since reset release
  int         m_edge;
  int         m_acc;
  logic [1:0] m_acc_a;
  logic [3:0] m_hist;
  logic [3:0] e_y;
  logic       e_ready;
  logic       e_busy;

  typedef struct {
    logic       v;
    logic [1:0] a;
    logic       c;
    logic [3:0] y;
    logic       rdy;
    logic       bsy;
    logic [3:0] h;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edge  = 0;
    m_acc   = -100;
    m_acc_a = 2'd0;
    m_hist  = 4'b0000;
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    logic [3:0] o;
    o = 4'b0001;
    return o << idx;
  endfunction

  task automatic model_edge(input logic v, input logic [1:0] a, input logic c);
    int  cyc;
    logic rdy_before;
    rdy_before = (m_edge >= m_acc + H + 2);
    if (rdy_before && v) begin
      m_acc   = m_edge;
      m_acc_a = a;
      m_hist  = (c ? 4'b0000 : m_hist) | onehot(a);
    end else if (c) begin
      m_hist = 4'b0000;
    end
    cyc     = m_edge + 1;
    e_y     = (cyc >= m_acc + 1 && cyc <= m_acc + H) ? onehot(m_acc_a) : 4'b0000;
    e_busy  = (cyc >= m_acc + 1 && cyc <= m_acc + H + 1);
    e_ready = !e_busy;
    m_edge++;
  endtask

  task automatic step(input logic v, input logic [1:0] a, input logic c);
    valid = v;
    A     = a;
    clr   = c;
    @(posedge clk);
    model_edge(v, a, c);
    #1;
    chk("model_Y", 8'(Y), 8'(e_y));
    chk("model_ready", 8'(ready), 8'(e_ready));
    chk("model_busy", 8'(busy), 8'(e_busy));
    chk("model_hist", 8'(hist), 8'(m_hist));
  endtask

  task automatic run_idle();
    int n;
    n = 0;
    while (!ready && n < 20) begin
      step(1'b0, 2'd0, 1'b0);
      n++;
    end
    chk("run_idle_bound", 8'(ready), 8'd1);
  endtask

  task automatic async_reset_check(input string nm);
    #3;
    rst_n = 1'b0;
    #1;
    chk({nm, "_Y"}, 8'(Y), 8'h0);
    chk({nm, "_ready"}, 8'(ready), 8'h1);
    chk({nm, "_busy"}, 8'(busy), 8'h0);
    chk({nm, "_hist"}, 8'(hist), 8'h0);
    valid = 1'b0;
    clr   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    tbl[0] = '{v:1'b1, a:2'd2, c:1'b0, y:4'b0100, rdy:1'b0, bsy:1'b1, h:4'b0100};
    tbl[1] = '{v:1'b0, a:2'd0, c:1'b0, y:4'b0100, rdy:1'b0, bsy:1'b1, h:4'b0100};
    tbl[2] = '{v:1'b1, a:2'd1, c:1'b0, y:4'b0100, rdy:1'b0, bsy:1'b1, h:4'b0100};
    tbl[3] = '{v:1'b0, a:2'd3, c:1'b0, y:4'b0100, rdy:1'b0, bsy:1'b1, h:4'b0100};
    tbl[4] = '{v:1'b0, a:2'd0, c:1'b0, y:4'b0000, rdy:1'b0, bsy:1'b1, h:4'b0100};
    tbl[5] = '{v:1'b0, a:2'd0, c:1'b0, y:4'b0000, rdy:1'b1, bsy:1'b0, h:4'b0100};

    model_reset();
    #12;
    chk("reset_Y", 8'(Y), 8'h0);
    chk("reset_ready", 8'(ready), 8'h1);
    chk("reset_busy", 8'(busy), 8'h0);
    chk("reset_hist", 8'(hist), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // single decode, table-driven
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].a, tbl[i].c);
      chk($sformatf("tbl%0d_Y", i), 8'(Y), 8'(tbl[i].y));
      chk($sformatf("tbl%0d_ready", i), 8'(ready), 8'(tbl[i].rdy));
      chk($sformatf("tbl%0d_busy", i), 8'(busy), 8'(tbl[i].bsy));
      chk($sformatf("tbl%0d_hist", i), 8'(hist), 8'(tbl[i].h));
    end

    // back-to-back with valid held high
    step(1'b0, 2'd0, 1'b1);
    chk("b2b_clr_hist", 8'(hist), 8'h0);
    step(1'b1, 2'd3, 1'b0);
    chk("b2b_first_Y", 8'(Y), 8'b1000);
    for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 1'b0);
    chk("b2b_idle_ready", 8'(ready), 8'h1);
    step(1'b1, 2'd0, 1'b0);
    chk("b2b_second_Y", 8'(Y), 8'b0001);
    chk("b2b_hist", 8'(hist), 8'b1001);
    run_idle();

    // ignore while busy
    step(1'b1, 2'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(i[0], 2'd1, 1'b0);
      chk("ignore_Y", 8'(Y), 8'b1000);
    end
    run_idle();
    chk("ignore_hist_bit1", 8'(hist[1]), 8'h0);

    // clear collision
    step(1'b0, 2'd0, 1'b1);
    step(1'b1, 2'd1, 1'b0);
    run_idle();
    step(1'b1, 2'd3, 1'b0);
    run_idle();
    chk("coll_pre_hist", 8'(hist), 8'b1010);
    step(1'b1, 2'd0, 1'b1);
    chk("coll_hist", 8'(hist), 8'b0001);
    step(1'b0, 2'd0, 1'b1);
    chk("clr_only_hist", 8'(hist), 8'b0000);
    chk("clr_only_Y", 8'(Y), 8'b0001);
    run_idle();

    // abort mid-DRIVE, then fresh accept
    step(1'b1, 2'd1, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    chk("abort_pre_Y", 8'(Y), 8'b0010);
    async_reset_check("abort");
    step(1'b1, 2'd2, 1'b0);
    chk("post_abort_Y", 8'(Y), 8'b0100);
    for (int i = 0; i < H - 1; i++) step(1'b0, 2'd0, 1'b0);
    chk("post_abort_full_hold", 8'(Y), 8'b0100);
    run_idle();

    // randomized against the timeline model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_reset_check("rand_rst");
      end else begin
        step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
